// File: rtl/boost_table_accum.sv
// boost_table_accum: histogram accumulator in front of an external dual-port
// table RAM (1-cycle registered read, read-first). The table is cleared and
// then incremented one index per cycle. A sample marked last starts a drain
// that streams every cell out and zeroes it behind the stream.
// Optional build macro: TABLE_SAT_EN. When defined, a cell at its maximum
// value saturates on increment. When undefined, the cell wraps to zero.
module boost_table_accum #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic                  bram_wr_en,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MAX_COUNT = {DATA_WIDTH{1'b1}};

  // Count increment; the overflow policy is fixed at build time.
  function automatic logic [DATA_WIDTH-1:0] bump(input logic [DATA_WIDTH-1:0] cnt);
`ifdef TABLE_SAT_EN
    if (cnt == MAX_COUNT) begin
      bump = cnt;
    end else begin
      bump = cnt + DATA_WIDTH'(1);
    end
`else
    bump = cnt + DATA_WIDTH'(1);
`endif
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   ptr_r;        // clear address / drain pointer
  logic                    rd_pend_r;    // drain read issued last cycle
  logic                    s1_valid_r;   // accumulate stage-1 occupied
  logic [ADDR_WIDTH-1:0]   s1_addr_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;    // address read in the previous cycle
  logic                    lw_en_r;      // write performed in the previous cycle
  logic [ADDR_WIDTH-1:0]   lw_addr_r;
  logic [DATA_WIDTH-1:0]   lw_data_r;
  logic                    out_valid_r;
  logic [ADDR_WIDTH-1:0]   out_addr_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic                    out_last_r;
  logic                    wr_en_s;
  logic                    in_hs_s;
  logic                    out_hs_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;

  assign in_hs_s  = in_valid && (state_r == ST_ACCUM);
  assign out_hs_s = out_valid_r && out_ready && (state_r == ST_DRAIN);

  // The RAM is read-first, so a write landing in the same cycle as the read
  // is invisible to it; take that write's data instead of bram_rdata.
  assign rd_data_s = (lw_en_r && (lw_addr_r == rd_addr_r)) ? lw_data_r : bram_rdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_ADDR) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_ACCUM: begin
        if (in_hs_s && in_last) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_FLUSH: state_nxt_s = ST_DRAIN;
      ST_DRAIN: begin
        if (out_hs_s && out_last_r) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // Output decode: input handshake and RAM port control per state.
  always_comb begin
    in_ready   = 1'b0;
    bram_raddr = {ADDR_WIDTH{1'b0}};
    wr_en_s    = 1'b0;
    bram_waddr = {ADDR_WIDTH{1'b0}};
    bram_wdata = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        wr_en_s    = 1'b1;
        bram_waddr = ptr_r;
      end
      ST_ACCUM, ST_FLUSH: begin
        if (state_r == ST_ACCUM) begin
          in_ready   = 1'b1;
          bram_raddr = in_addr;
        end else begin
          // First drain read goes out while the last increment lands.
          bram_raddr = ptr_r;
        end
        if (s1_valid_r) begin
          wr_en_s    = 1'b1;
          bram_waddr = s1_addr_r;
          bram_wdata = bump(rd_data_s);
        end else begin
          wr_en_s    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (out_hs_s) begin
          wr_en_s    = 1'b1;
          bram_waddr = out_addr_r;
          bram_raddr = ptr_r + ADDR_WIDTH'(1);
        end else begin
          bram_raddr = ptr_r;
        end
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // No RAM write may escape while reset is held, even though CLEAR is decoded.
  assign bram_wr_en = wr_en_s & ~rst;

  // Accumulate stage-1 and forwarding history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= {ADDR_WIDTH{1'b0}};
      rd_addr_r  <= {ADDR_WIDTH{1'b0}};
      lw_en_r    <= 1'b0;
      lw_addr_r  <= {ADDR_WIDTH{1'b0}};
      lw_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      s1_valid_r <= in_hs_s;
      s1_addr_r  <= in_addr;
      rd_addr_r  <= bram_raddr;
      lw_en_r    <= bram_wr_en;
      lw_addr_r  <= bram_waddr;
      lw_data_r  <= bram_wdata;
    end
  end

  // Clear/drain pointer and drain read-pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          ptr_r     <= ptr_r + ADDR_WIDTH'(1);
          rd_pend_r <= 1'b0;
        end
        ST_ACCUM: begin
          ptr_r     <= {ADDR_WIDTH{1'b0}};
          rd_pend_r <= 1'b0;
        end
        ST_FLUSH: begin
          ptr_r     <= {ADDR_WIDTH{1'b0}};
          rd_pend_r <= 1'b1;
        end
        ST_DRAIN: begin
          if (out_hs_s && out_last_r) begin
            ptr_r     <= {ADDR_WIDTH{1'b0}};
            rd_pend_r <= 1'b0;
          end else if (out_hs_s) begin
            ptr_r     <= ptr_r + ADDR_WIDTH'(1);
            rd_pend_r <= 1'b1;
          end else begin
            rd_pend_r <= 1'b0;
          end
        end
        default: begin
          ptr_r     <= {ADDR_WIDTH{1'b0}};
          rd_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Drain output registers: load on read return, drop valid on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_addr_r  <= {ADDR_WIDTH{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
    end else if ((state_r == ST_DRAIN) && rd_pend_r) begin
      out_valid_r <= 1'b1;
      out_addr_r  <= ptr_r;
      out_data_r  <= rd_data_s;
      out_last_r  <= (ptr_r == LAST_ADDR);
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_addr  = out_addr_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

endmodule

// File: doc/boost_table_accum.md
BOOST_TABLE_ACCUM -- requirements
Module: boost_table_accum

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: log2 of the table depth, which is 16 count cells.
REQ-002 Parameter DATA_WIDTH, default 8: width of each count cell.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: a sample cell index is presented.
REQ-006 Port in_ready, output, 1: the block accepts an index this cycle.
REQ-007 Port in_addr, input, ADDR_WIDTH: the cell index to increment.
REQ-008 Port in_last, input, 1: marks the final sample of a SNP pair, qualified by the handshake.
REQ-009 Port out_valid, output, 1: a drained count is presented.
REQ-010 Port out_ready, input, 1: the consumer accepts the drained count.
REQ-011 Port out_addr, output, ADDR_WIDTH: the cell index of the drained count.
REQ-012 Port out_data, output, DATA_WIDTH: the drained count.
REQ-013 Port out_last, output, 1: high with the count for cell 2**ADDR_WIDTH-1.
REQ-014 Ports bram_raddr (output, ADDR_WIDTH), bram_waddr (output, ADDR_WIDTH), bram_wr_en (output, 1) and bram_wdata (output, DATA_WIDTH) SHALL drive the external dual-port table RAM.
REQ-015 Port bram_rdata, input, DATA_WIDTH: the RAM read data.
- The RAM has a registered read of 1 cycle latency.
- On the same address, a read returns the old data (read-first).

Function
REQ-016 The block SHALL implement an FSM with four states: CLEAR, ACCUM, FLUSH and DRAIN.
REQ-017 CLEAR SHALL write zero to addresses 0 through 2**ADDR_WIDTH-1, one per cycle, then go to ACCUM; in_ready SHALL be 0 during CLEAR.
REQ-018 ACCUM SHALL hold in_ready=1 and sustain 1 index per cycle.
- Stage 0 (handshake cycle): bram_raddr=in_addr.
- Stage 1 (next cycle): bram_wr_en=1, bram_waddr=stage-1 address, bram_wdata=count+1.
REQ-019 Hazard forwarding SHALL apply when stage-1 address equals the address written in the cycle its read was issued: the count SHALL be taken from that write's data, not from bram_rdata.
- Back-to-back identical indices SHALL therefore increment correctly.
REQ-020 Arithmetic SHALL be DATA_WIDTH-bit unsigned; overflow behaviour is set by REQ-033.
REQ-021 A handshake with in_last=1 SHALL be followed immediately by FLUSH.
- in_ready=0 in FLUSH.
- FLUSH lasts 1 cycle, until the stage-1 write completes.
- Then go to DRAIN.
REQ-022 DRAIN SHALL walk a pointer from 0 to 2**ADDR_WIDTH-1.
- Issue a read, capture bram_rdata into the out_* registers, assert out_valid.
- Hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 On each out handshake, bram_wr_en SHALL be 1 with bram_waddr equal to the drained address and bram_wdata=0, clearing the cell for the next pair.
REQ-024 The handshake on the last cell (out_last=1) SHALL return the FSM to ACCUM with in_ready=1 on the next cycle.
REQ-025 A DRAIN cell SHALL take at most 2 cycles when out_ready is held at 1.
REQ-026 in_valid SHALL be ignored whenever in_ready=0.
REQ-027 in_last on the very first accepted sample SHALL still produce a full drain.

Reset
REQ-028 While rst=1, the outputs SHALL be held as follows: in_ready=0, out_valid=0, out_last=0, bram_wr_en=0, out_addr=0, out_data=0, bram_raddr=0, bram_waddr=0, bram_wdata=0.
REQ-029 rst SHALL clear the pipeline, forwarding registers and pointers, and set the state to CLEAR.
REQ-030 Reset asserted mid-ACCUM or mid-DRAIN SHALL discard any in-flight sample or drained count, and SHALL re-run the full CLEAR after release.
REQ-031 On the first edge after rst deasserts, CLEAR SHALL write address 0.

Configuration
REQ-032 Macro TABLE_SAT_EN SHALL select the overflow behaviour.
REQ-033 When TABLE_SAT_EN is defined, a cell at 2**DATA_WIDTH-1 SHALL stay at that value on increment; when it is undefined, the cell SHALL wrap to 0.

Verification
REQ-034 Release reset -> bram_wr_en=1 with wdata=0 for addresses 0..15 over 16 cycles, then in_ready=1 on cycle 17.
REQ-035 Send indices 3,3,3,5 with last on 5, out_ready=1 -> 16 outputs: addr3=3, addr5=1, all other cells 0, out_last only on addr15.
REQ-036 Send 300 consecutive index-7 samples with DATA_WIDTH=8 -> addr7 reads 255 with TABLE_SAT_EN, 44 without it.
REQ-037 Toggle out_ready 0/1 every cycle during DRAIN -> out_data/out_addr stay stable while stalled, there are no lost or duplicate cells, and a second pair drains all zeros except its own counts.
REQ-038 Assert rst 2 cycles after entering DRAIN -> out_valid=0 immediately, then a full 16-cycle CLEAR, and the next pair's counts carry no residue.
REQ-039 Send alternating indices 1,2,1,2 back-to-back followed by 4,4 -> final counts addr1=2, addr2=2, addr4=2, proving forwarding.
